// File: rtl/l2_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single L2 port.
// Round-robin between simultaneous requesters; L2 command is registered and held until mem_resp.
module l2_arbiter #(
  parameter logic FIRST_PRIO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state, state_nxt;
  logic          last_grant;   // 1 = data port completed last
  logic          hist_vld;     // a transaction has completed since reset
  logic          take, grant_d;
  logic          d_req;
  logic [31:0]   hold_addr;
  logic [255:0]  hold_wdata;
  logic          hold_rd, hold_wr;

  assign d_req = d_read | d_write;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    grant_d   = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && d_req) begin
          take    = 1'b1;
          grant_d = hist_vld ? ~last_grant : FIRST_PRIO;
        end else if (d_req) begin
          take    = 1'b1;
          grant_d = 1'b1;
        end else if (i_read) begin
          take    = 1'b1;
        end
        if (take) state_nxt = grant_d ? SERVE_D : SERVE_I;
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_resp    = 1'b1;
          state_nxt = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_resp    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      hist_vld   <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_rd    <= 1'b0;
      hold_wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        hold_addr  <= grant_d ? d_address : i_address;
        hold_wdata <= grant_d ? d_wdata : '0;
        // read+write together from the data port resolves to a write
        hold_rd    <= ~grant_d | ~d_write;
        hold_wr    <= grant_d & d_write;
      end
      if (i_resp || d_resp) begin
        last_grant <= d_resp;
        hist_vld   <= 1'b1;
        hold_rd    <= 1'b0;
        hold_wr    <= 1'b0;
      end
    end
  end

  assign mem_read    = hold_rd;
  assign mem_write   = hold_wr;
  assign mem_address = hold_addr;
  assign mem_wdata   = hold_wdata;
  assign i_rdata     = (state == SERVE_I) ? mem_rdata : '0;
  assign d_rdata     = (state == SERVE_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios, then random traffic checked against a
// transaction-level model of requesters, arbitration and an L2 with random latency.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, d_read, d_write, mem_resp;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata, mem_rdata;
  logic [255:0] i_rdata, d_rdata, mem_wdata;
  logic         i_resp, d_resp, mem_read, mem_write;
  logic [31:0]  mem_address;

  int total = 0;
  int bad   = 0;

  localparam bit FP = 1'b1;

  l2_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  // Called one step after the edge that should have started the transaction.
  task automatic serve(input bit port_d, input logic [31:0] addr, input bit wr,
                       input logic [255:0] wd, input int lat, input bit drop);
    logic [255:0] rd;
    for (int k = 1; k <= lat; k++) begin
      rd = rnd256();
      if (drop && k == 2) begin i_read = 0; d_read = 0; d_write = 0; end
      mem_resp  = (k == lat);
      mem_rdata = rd;
      #1;
      chk("mem_read", mem_read, !wr);
      chk("mem_write", mem_write, wr);
      chk("mem_address", mem_address, addr);
      if (wr) chk("mem_wdata", mem_wdata, wd);
      chk("i_resp", i_resp, !port_d && k == lat);
      chk("d_resp", d_resp, port_d && k == lat);
      if (k == lat) chk("rdata", port_d ? d_rdata : i_rdata, rd);
      tick();
    end
    mem_resp = 0;
    #1;
    chk("idle_mem_read", mem_read, 0);
    chk("idle_mem_write", mem_write, 0);
    chk("idle_resp", {i_resp, d_resp}, 0);
  endtask

  // random-phase model state
  bit           want [2];
  logic [31:0]  raddr [2];
  logic [255:0] rwd;
  logic [1:0]   rcmd;
  bit           m_busy, m_port;
  int           m_cnt, m_lat, m_last;
  logic [31:0]  m_addr;
  logic [255:0] m_wd;
  logic [1:0]   m_cmd;
  bit           line_i, line_d, ireq, dreq, win, exp_rd, exp_wr;

  initial begin
    logic [255:0] wd;
    rst_n = 0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    mem_resp = 1;
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    mem_resp = 0;
    rst_n = 1;

    // single instruction read
    i_read = 1; i_address = 32'h0000_1000;
    tick(); serve(0, 32'h0000_1000, 0, '0, 3, 0);
    i_read = 0;

    // simultaneous after reset: data first, then instruction
    rst_n = 0; tick(); rst_n = 1;
    i_read = 1; d_read = 1; i_address = 32'h3000; d_address = 32'h4000;
    tick(); serve(1, 32'h4000, 0, '0, 2, 0);
    d_read = 0;
    tick(); serve(0, 32'h3000, 0, '0, 2, 0);

    // sustained contention alternates D,I,D,I,D,I
    d_read = 1;
    for (int t = 0; t < 6; t++) begin
      tick();
      serve(t % 2 == 0, (t % 2 == 0) ? 32'h4000 : 32'h3000, 0, '0, 1 + t % 3, 0);
    end
    i_read = 0; d_read = 0;

    // data write held for 5 cycles
    wd = {8{32'h1234_5678}};
    d_write = 1; d_address = 32'h0000_2040; d_wdata = wd;
    tick(); serve(1, 32'h0000_2040, 1, wd, 5, 0);
    d_write = 0;

    // stray mem_resp in IDLE
    for (int t = 0; t < 2; t++) begin
      tick(); mem_resp = 1; #1;
      chk("stray_resp", {i_resp, d_resp}, 0);
      chk("stray_cmd", {mem_read, mem_write}, 0);
    end
    mem_resp = 0;

    // read and write together -> write
    wd = rnd256();
    d_read = 1; d_write = 1; d_address = 32'h5000; d_wdata = wd;
    tick(); serve(1, 32'h5000, 1, wd, 2, 0);
    d_read = 0; d_write = 0;

    // requester drops mid-transaction
    d_read = 1; d_address = 32'h6000;
    tick(); serve(1, 32'h6000, 0, '0, 3, 1);

    // reset mid SERVE_D, late mem_resp ignored, then normal I read
    d_read = 1; d_address = 32'h7000;
    tick(); tick();
    rst_n = 0; d_read = 0;
    tick();
    rst_n = 1; mem_resp = 1;
    #1;
    chk("rst_mid_cmd", {mem_read, mem_write}, 0);
    chk("rst_mid_d_resp", d_resp, 0);
    tick();
    chk("rst_late_resp", {i_resp, d_resp}, 0);
    mem_resp = 0;
    i_read = 1; i_address = 32'h8000;
    tick(); serve(0, 32'h8000, 0, '0, 2, 0);
    i_read = 0;

    // random traffic against the model
    rst_n = 0; tick(); rst_n = 1;
    want[0] = 0; want[1] = 0; m_busy = 0; m_last = -1; m_cnt = 0; m_lat = 0;
    m_port = 0; m_addr = '0; m_wd = '0; m_cmd = '0; rcmd = 2'b01; rwd = '0;
    raddr[0] = '0; raddr[1] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++)
        if (!want[p] && $urandom_range(0, 3) == 0) begin
          want[p]  = 1;
          raddr[p] = $urandom();
          if (p == 1) begin
            rcmd = 2'($urandom_range(1, 3));
            rwd  = rnd256();
          end
        end
      line_i = want[0] && !(m_busy && m_port == 0 && $urandom_range(0, 2) == 0);
      line_d = want[1] && !(m_busy && m_port == 1 && $urandom_range(0, 2) == 0);
      i_read = line_i; i_address = raddr[0];
      d_read = line_d && rcmd[0]; d_write = line_d && rcmd[1];
      d_address = raddr[1]; d_wdata = rwd;
      mem_resp  = m_busy ? (m_cnt == m_lat) : ($urandom_range(0, 7) == 0);
      mem_rdata = rnd256();
      #1;
      exp_rd = m_busy && (m_port == 0 || !m_cmd[1]);
      exp_wr = m_busy && m_port == 1 && m_cmd[1];
      chk("r_mem_read", mem_read, exp_rd);
      chk("r_mem_write", mem_write, exp_wr);
      if (m_busy) chk("r_mem_address", mem_address, m_addr);
      if (exp_wr) chk("r_mem_wdata", mem_wdata, m_wd);
      chk("r_i_resp", i_resp, m_busy && m_port == 0 && mem_resp);
      chk("r_d_resp", d_resp, m_busy && m_port == 1 && mem_resp);
      if (m_busy && mem_resp) chk("r_rdata", m_port ? d_rdata : i_rdata, mem_rdata);
      if (m_busy) begin
        if (mem_resp) begin
          m_busy = 0; m_last = int'(m_port); want[m_port] = 0;
        end else m_cnt++;
      end else begin
        ireq = i_read; dreq = d_read || d_write;
        if (ireq || dreq) begin
          if (ireq && dreq) win = (m_last < 0) ? FP : (m_last == 1 ? 1'b0 : 1'b1);
          else win = dreq;
          m_busy = 1; m_port = win; m_cnt = 1; m_lat = $urandom_range(1, 4);
          m_addr = win ? d_address : i_address;
          m_wd   = d_wdata;
          m_cmd  = win ? {d_write, d_read} : 2'b01;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
